// File: rtl/adpcm_ctrl_pkg.sv
// Shared encodings and sizing for the ADPCM predictor sequencing control.
package adpcm_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StCalc   = 3'd1,
        StWaitDq = 3'd2,
        StSettle = 3'd3,
        StStrobe = 3'd4
    } seq_state_e;

    localparam int unsigned SettleCycDefault  = 2;
    localparam int unsigned TimeoutCycDefault = 64;
    localparam int unsigned SettleCntW        = 4;
    localparam int unsigned TimeoutCntW       = 8;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter that holds at zero instead of wrapping.
module seq_down_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/pred_seq_ctrl.sv
// Sequences one predictor cycle per sample: compute SE, wait for DQ, settle, strobe delays.
module pred_seq_ctrl
    import adpcm_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = SettleCycDefault,
    parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_strb,
    input  logic       done,
    input  logic       dq_valid,
    input  logic       err_clr,
    output logic       start_trig,
    output logic       dly_strb,
    output logic       se_valid,
    output logic       busy,
    output logic       overrun,
    output logic       timeout_err,
    output logic [2:0] state_dbg
);

    localparam logic [TimeoutCntW-1:0] TimeoutLoad = TimeoutCntW'(TIMEOUT_CYC - 1);
    localparam logic [SettleCntW-1:0]  SettleLoad  = SettleCntW'(SETTLE_CYC - 1);

    seq_state_e state_q, state_d;
    logic to_load, to_dec, to_zero;
    logic st_load, st_dec, st_zero;
    logic se_valid_d, timeout_evt, overrun_evt;
    logic start_trig_q, dly_strb_q, se_valid_q, busy_q, overrun_q, timeout_err_q;

    seq_down_counter #(
        .Width (TimeoutCntW)
    ) u_timeout_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (to_load),
        .load_val (TimeoutLoad),
        .dec      (to_dec),
        .zero     (to_zero)
    );

    seq_down_counter #(
        .Width (SettleCntW)
    ) u_settle_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (st_load),
        .load_val (SettleLoad),
        .dec      (st_dec),
        .zero     (st_zero)
    );

    always_comb begin
        state_d     = state_q;
        to_load     = 1'b0;
        to_dec      = 1'b0;
        st_load     = 1'b0;
        st_dec      = 1'b0;
        se_valid_d  = 1'b0;
        timeout_evt = 1'b0;
        overrun_evt = sample_strb && (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                if (sample_strb) begin
                    state_d = StCalc;
                    to_load = 1'b1;
                end
            end
            StCalc: begin
                // done on the last allowed cycle still counts as success
                if (done) begin
                    state_d    = StWaitDq;
                    se_valid_d = 1'b1;
                end else if (to_zero) begin
                    state_d     = StIdle;
                    timeout_evt = 1'b1;
                end else begin
                    to_dec = 1'b1;
                end
            end
            StWaitDq: begin
                if (dq_valid) begin
                    state_d = StSettle;
                    st_load = 1'b1;
                end
            end
            StSettle: begin
                if (st_zero) begin
                    state_d = StStrobe;
                end else begin
                    st_dec = 1'b1;
                end
            end
            StStrobe: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            start_trig_q  <= 1'b0;
            dly_strb_q    <= 1'b0;
            se_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_trig_q  <= (state_d == StCalc);
            dly_strb_q    <= (state_d == StStrobe);
            se_valid_q    <= se_valid_d;
            busy_q        <= (state_d != StIdle);
            // a new error event overrides a simultaneous clear
            overrun_q     <= (overrun_q && !err_clr) || overrun_evt;
            timeout_err_q <= (timeout_err_q && !err_clr) || timeout_evt;
        end
    end

    assign start_trig  = start_trig_q;
    assign dly_strb    = dly_strb_q;
    assign se_valid    = se_valid_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pred_seq_ctrl.sv
// Self-checking bench for pred_seq_ctrl: table vectors, corner sequences and random scenarios.
module tb_pred_seq_ctrl;

    localparam int S = 2;
    localparam int T = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_strb, done, dq_valid, err_clr;
    logic       start_trig, dly_strb, se_valid, busy, overrun, timeout_err;
    logic [2:0] state_dbg;

    int n_chk  = 0;
    int n_fail = 0;
    bit ov_m   = 1'b0;
    bit to_m   = 1'b0;

    typedef struct {
        string name;
        int    d;
        int    q;
        int    x;
        int    clr;
        bit    exp_ov;
        bit    exp_to;
    } vec_t;

    vec_t tbl[11];

    pred_seq_ctrl #(
        .SETTLE_CYC  (S),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_strb (sample_strb),
        .done        (done),
        .dq_valid    (dq_valid),
        .err_clr     (err_clr),
        .start_trig  (start_trig),
        .dly_strb    (dly_strb),
        .se_valid    (se_valid),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_cycle(input string name, input logic [2:0] est, input bit se_e);
        logic [8:0] exp_v, act_v;
        exp_v = {(est == 3'd1), (est == 3'd4), se_e, (est != 3'd0), ov_m, to_m, est};
        act_v = {start_trig, dly_strb, se_valid, busy, overrun, timeout_err, state_dbg};
        n_chk++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b (start,dly,se,busy,ovr,tmo,state)",
                     name, $time, act_v, exp_v);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    // One sample period. Indices are posedges after the accepted sample_strb (posedge 0):
    // d = done pulse, q = dq_valid pulse, x = extra sample_strb, clr = err_clr (0 = none).
    task automatic run_seq(input string name, input int d, input int q, input int x,
                           input int clr, input int len_in);
        bit          ok;
        int          e, len;
        logic [2:0]  est;
        ok  = (d >= 1) && (d <= T);
        e   = ok ? q + S : T - 1;
        len = (len_in > 0) ? len_in : e + 3;
        sample_strb = 1'b1;
        done        = 1'b0;
        dq_valid    = 1'b0;
        err_clr     = 1'b0;
        for (int k = 0; k <= len; k++) begin
            @(posedge clk);
            if (clr >= 1 && k == clr) begin
                ov_m = 1'b0;
                to_m = 1'b0;
            end
            if (x >= 1 && k == x && x <= e + 1) ov_m = 1'b1;
            if (!ok && k == T) to_m = 1'b1;
            @(negedge clk);
            if (ok) begin
                if (k < d)          est = 3'd1;
                else if (k < q)     est = 3'd2;
                else if (k < q + S) est = 3'd3;
                else if (k == q + S) est = 3'd4;
                else                est = 3'd0;
            end else begin
                est = (k < T) ? 3'd1 : 3'd0;
            end
            check_cycle(name, est, ok && (k == d));
            sample_strb = (k + 1 == x);
            done        = (k + 1 == d);
            dq_valid    = (k + 1 == q);
            err_clr     = (k + 1 == clr);
        end
        sample_strb = 1'b0;
        done        = 1'b0;
        dq_valid    = 1'b0;
        err_clr     = 1'b0;
    endtask

    task automatic clear_flags();
        err_clr = 1'b1;
        @(posedge clk);
        ov_m = 1'b0;
        to_m = 1'b0;
        @(negedge clk);
        err_clr = 1'b0;
        check_cycle("err_clr_idle", 3'd0, 1'b0);
    endtask

    initial begin
        int d, q, x, clr, e;
        bit ok;

        tbl[0]  = '{"nominal",          20, 23,  0,  0, 1'b0, 1'b0};
        tbl[1]  = '{"timeout",           0,  0,  0,  0, 1'b0, 1'b1};
        tbl[2]  = '{"done_at_limit",    64, 66,  0,  0, 1'b0, 1'b0};
        tbl[3]  = '{"done_past_limit",  65,  0,  0,  0, 1'b0, 1'b1};
        tbl[4]  = '{"overrun_wait_dq",  10, 15, 12,  0, 1'b1, 1'b0};
        tbl[5]  = '{"overrun_cleared",  10, 15, 12, 19, 1'b0, 1'b0};
        tbl[6]  = '{"clr_with_timeout",  0,  0,  0, 64, 1'b0, 1'b1};
        tbl[7]  = '{"overrun_strobe",    5,  8, 11,  0, 1'b1, 1'b0};
        tbl[8]  = '{"overrun_calc",      5,  7,  3,  0, 1'b1, 1'b0};
        tbl[9]  = '{"fast_done",         1,  2,  0,  0, 1'b0, 1'b0};
        tbl[10] = '{"overrun_settle",    4,  6,  7,  0, 1'b1, 1'b0};

        reset       = 1'b0;
        sample_strb = 1'b0;
        done        = 1'b0;
        dq_valid    = 1'b0;
        err_clr     = 1'b0;
        repeat (3) @(negedge clk);
        check_cycle("reset_state", 3'd0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_cycle("after_release", 3'd0, 1'b0);

        foreach (tbl[i]) begin
            clear_flags();
            run_seq(tbl[i].name, tbl[i].d, tbl[i].q, tbl[i].x, tbl[i].clr, 0);
            check_bit({tbl[i].name, "_overrun"}, overrun, tbl[i].exp_ov);
            check_bit({tbl[i].name, "_timeout_err"}, timeout_err, tbl[i].exp_to);
        end

        // stray dq_valid while idle must be ignored
        clear_flags();
        for (int k = 0; k < 6; k++) begin
            dq_valid = k[0];
            @(negedge clk);
            check_cycle("stray_dq_idle", 3'd0, 1'b0);
        end
        dq_valid = 1'b0;

        // reset one cycle into SETTLE aborts without a delay strobe
        run_seq("pre_reset", 5, 8, 0, 0, 8);
        reset = 1'b0;
        #1;
        ov_m = 1'b0;
        to_m = 1'b0;
        check_cycle("reset_mid_settle", 3'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_cycle("held_in_reset", 3'd0, 1'b0);
        end
        reset = 1'b1;
        @(negedge clk);
        run_seq("post_reset_nominal", 20, 23, 0, 0, 0);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 9) < 7) d = $urandom_range(1, T);
            else if ($urandom_range(0, 1) == 1) d = $urandom_range(T + 1, T + 5);
            else d = 0;
            ok  = (d >= 1) && (d <= T);
            q   = ok ? d + $urandom_range(1, 6) : $urandom_range(1, T);
            e   = ok ? q + S : T - 1;
            x   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, e + 1) : 0;
            clr = ($urandom_range(0, 1) == 1) ? $urandom_range(1, e + 3) : 0;
            run_seq("random", d, q, x, clr, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pred_seq_ctrl.md
PRED_SEQ_CTRL -- requirements
Module: pred_seq_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 2: cycles between dq_valid and dly_strb, allowing the ADDB/FLOATB/UPA/LIM paths to settle; legal range 1..15.
REQ-002 Parameter TIMEOUT_CYC, default 64: maximum cycles from start_trig rise to done; legal range 8..255.
REQ-003 Port clk, input, 1: single block clock, the same clock that drives FMULT/ACCUM.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port sample_strb, input, 1: one-cycle pulse marking a new 8 kHz sample period.
REQ-006 Port done, input, 1: predictor accumulate-complete flag; SE is valid while it is high.
REQ-007 Port dq_valid, input, 1: one-cycle pulse from the quantizer side marking DQ valid for the current sample.
REQ-008 Port err_clr, input, 1: one-cycle pulse that clears the sticky error flags.
REQ-009 Port start_trig, output, 1: request to the predictor to compute SE/SEZ.
REQ-010 Port dly_strb, output, 1: one-cycle pulse that updates all predictor delay elements.
REQ-011 Port se_valid, output, 1: one-cycle pulse when SE may be sampled.
REQ-012 Port busy, output, 1: high in every state except IDLE.
REQ-013 Port overrun, output, 1: sticky flag; a sample_strb arrived while busy.
REQ-014 Port timeout_err, output, 1: sticky flag; done did not arrive within TIMEOUT_CYC.
REQ-015 Port state_dbg, output, 3: current state encoding.

Function
REQ-016 The FSM SHALL have the states IDLE=0, CALC=1, WAIT_DQ=2, SETTLE=3, STROBE=4.
REQ-017 IDLE: when sample_strb=1, the FSM SHALL enter CALC on the next edge, and start_trig SHALL rise that same edge.
REQ-018 CALC: start_trig SHALL stay high until done is sampled high.
REQ-019 CALC: on done=1, start_trig SHALL fall, se_valid SHALL pulse for exactly one cycle, and the FSM SHALL enter WAIT_DQ.
REQ-020 CALC: a cycle counter SHALL count each CALC cycle.
REQ-021 CALC: if the counter reaches TIMEOUT_CYC without done, the FSM SHALL set timeout_err, drop start_trig, and return to IDLE without a dly_strb pulse.
REQ-022 WAIT_DQ: on dq_valid=1, the FSM SHALL load the settle counter with SETTLE_CYC-1 and enter SETTLE.
REQ-023 WAIT_DQ: dq_valid seen in any other state SHALL be ignored.
REQ-024 SETTLE: the settle counter SHALL decrement each cycle; at 0 the FSM SHALL enter STROBE.
REQ-025 STROBE: dly_strb SHALL be high for exactly this one cycle, after which the FSM SHALL enter IDLE unconditionally.
REQ-026 Latency from dq_valid to dly_strb SHALL be SETTLE_CYC+1 cycles.
REQ-027 Latency from done sampled to se_valid SHALL be 1 cycle.
REQ-028 A sample_strb in any state other than IDLE SHALL set overrun and SHALL NOT restart the sequence.
REQ-029 A sample_strb in STROBE SHALL set overrun; IDLE is not re-entered early.
REQ-030 When err_clr and a new error event occur in the same cycle, the flag SHALL be set (set wins).
REQ-031 At most one dly_strb SHALL occur per accepted sample_strb.
REQ-032 start_trig and dly_strb SHALL never be high in the same cycle.
REQ-033 All outputs SHALL be registered, with no combinational path from input to output.
REQ-034 The counters SHALL saturate and never wrap.

Reset
REQ-035 While reset=0, the FSM SHALL be in IDLE.
REQ-036 While reset=0, start_trig, dly_strb, se_valid, busy, overrun and timeout_err SHALL all be 0, and state_dbg SHALL be 0.
REQ-037 While reset=0, both counters SHALL be 0.
REQ-038 A reset asserted mid-sequence SHALL abort it immediately with no dly_strb pulse, so the delay elements keep their prior state.
REQ-039 The first sample_strb after reset release SHALL be accepted normally.

Structure
REQ-040 The state encodings, SETTLE_CYC/TIMEOUT_CYC default values and counter widths SHALL be defined in the shared package adpcm_ctrl_pkg.
REQ-041 The block SHALL use one sub-module, seq_down_counter, as a loadable saturating down-counter, instantiated twice: once for timeout and once for settle.

Verification
REQ-042 Nominal: sample_strb, done after 20 cycles, dq_valid 3 cycles after se_valid -> se_valid 1 cycle after done; with SETTLE_CYC=2, dly_strb 3 cycles after dq_valid; busy ends 1 cycle after dly_strb.
REQ-043 Timeout: sample_strb with done held 0 -> start_trig falls and timeout_err=1 at cycle 64; no dly_strb; next sample_strb accepted.
REQ-044 Overrun: sample_strb repeated while in WAIT_DQ -> overrun=1, the sequence completes once with a single dly_strb; an err_clr pulse then clears overrun.
REQ-045 Reset mid-SETTLE: deassert reset 1 cycle after dq_valid -> all outputs 0 at once, no dly_strb; after release, a full sequence runs normally.
REQ-046 Simultaneous: err_clr in the same cycle as a timeout -> timeout_err=1 afterwards.
REQ-047 Stray input: dq_valid pulsed in IDLE -> no state change and no dly_strb.
